// File: rtl/nios2_qsys_nios2_cpu_debug_pkg.sv
// Shared types for the OCI debug RAM arbiter: FSM state encoding and grant owner.
package nios2_qsys_nios2_cpu_debug_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_AV_WR      = 3'd1,
        ST_AV_RD      = 3'd2,
        ST_AV_RD_DONE = 3'd3,
        ST_J_WR       = 3'd4,
        ST_J_RD       = 3'd5,
        ST_J_RD_DONE  = 3'd6
    } arb_state_e;

    typedef enum logic {
        OWNER_CPU  = 1'b0,
        OWNER_JTAG = 1'b1
    } grant_owner_e;

    // On a tie the requester that was not served last wins.
    function automatic grant_owner_e rr_pick(logic req_cpu, logic req_jtag, grant_owner_e last);
        if (req_cpu && req_jtag) begin
            return (last == OWNER_CPU) ? OWNER_JTAG : OWNER_CPU;
        end
        return req_jtag ? OWNER_JTAG : OWNER_CPU;
    endfunction

endpackage

// File: rtl/nios2_qsys_nios2_cpu_debug_mem_rr_arb.sv
// Two-requester round-robin picker (CPU vs JTAG) holding the last-grant owner.
module nios2_qsys_nios2_cpu_debug_mem_rr_arb
    import nios2_qsys_nios2_cpu_debug_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_cpu,
    input  logic         req_jtag,
    input  logic         take,
    output logic         grant_valid,
    output grant_owner_e grant_owner
);

    grant_owner_e last_grant;

    assign grant_valid = req_cpu | req_jtag;
    assign grant_owner = rr_pick(req_cpu, req_jtag, last_grant);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= OWNER_CPU;
        end else if (take && grant_valid) begin
            last_grant <= grant_owner;
        end
    end

endmodule

// File: rtl/nios2_qsys_nios2_cpu_debug_mem_arbiter.sv
// Arbitrates the OCI debug RAM between the CPU Avalon port and JTAG commands.
// Build option: DEBUG_MEM_ARB_OVF_EN enables the sticky JTAG overflow flag.
//
// state         | meaning
// ST_IDLE       | no access; grant CPU or pending JTAG (round-robin on tie)
// ST_AV_WR      | CPU write on RAM port, Avalon write completes
// ST_AV_RD      | CPU read issued to RAM
// ST_AV_RD_DONE | RAM data returned to Avalon, read completes
// ST_J_WR       | JTAG write on RAM port, jtag_addr advances
// ST_J_RD       | JTAG read issued to RAM
// ST_J_RD_DONE  | RAM data captured into MonDReg, jtag_addr advances
module nios2_qsys_nios2_cpu_debug_mem_arbiter
    import nios2_qsys_nios2_cpu_debug_pkg::*;
#(
    parameter int RAM_AW = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [RAM_AW-1:0] av_address,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [31:0]       av_writedata,
    output logic              av_waitrequest,
    output logic [31:0]       av_readdata,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_wr,
    output logic              ram_rd,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [31:0]       MonDReg,
    output logic              jtag_busy,
    output logic              jtag_ovf
);

    arb_state_e        state;
    logic [RAM_AW-1:0] jtag_addr;
    logic              jtag_pend;
    logic              jtag_pend_wr;
    logic [31:0]       jtag_pend_data;
    logic [31:0]       av_rdata_q;
    logic              av_req;
    logic              strobe_any;
    logic              strobe_ok;
    logic              grant_valid;
    grant_owner_e      grant_owner;
    logic              grant_take;
    logic              jtag_take;
    logic              unused_jdo;

    assign unused_jdo = ^{jdo[37], jdo[36], jdo[2:0]};

    assign av_req     = av_read | av_write;
    assign strobe_any = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

    // J_WR and J_RD_DONE are completing cycles, so they do not count as busy.
    assign jtag_busy  = jtag_pend | (state == ST_J_RD);
    assign strobe_ok  = strobe_any & ~jtag_busy;

    assign grant_take = (state == ST_IDLE) & grant_valid;
    assign jtag_take  = grant_take & (grant_owner == OWNER_JTAG);

    assign av_waitrequest = av_req & ~((state == ST_AV_WR) | (state == ST_AV_RD_DONE));
    assign av_readdata    = (state == ST_AV_RD_DONE) ? ram_rdata : av_rdata_q;

    nios2_qsys_nios2_cpu_debug_mem_rr_arb u_rr_arb (
        .clk         (clk),
        .rst_n       (reset_n),
        .req_cpu     (av_req),
        .req_jtag    (jtag_pend),
        .take        (grant_take),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            jtag_addr      <= '0;
            jtag_pend      <= 1'b0;
            jtag_pend_wr   <= 1'b0;
            jtag_pend_data <= '0;
        end else begin
            if (state == ST_J_WR || state == ST_J_RD_DONE) begin
                jtag_addr <= jtag_addr + 1'b1;
            end
            if (jtag_take) begin
                jtag_pend <= 1'b0;
            end
            // A fresh address load overrides the post-access increment.
            if (strobe_ok) begin
                if (take_action_ocimem_a) begin
                    jtag_addr <= jdo[RAM_AW+25:26];
                    if (jdo[35]) begin
                        jtag_pend    <= 1'b1;
                        jtag_pend_wr <= 1'b0;
                    end
                end else if (take_action_ocimem_b) begin
                    jtag_pend      <= 1'b1;
                    jtag_pend_wr   <= 1'b1;
                    jtag_pend_data <= jdo[34:3];
                end else begin
                    jtag_pend    <= 1'b1;
                    jtag_pend_wr <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            ram_wr     <= 1'b0;
            ram_rd     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            av_rdata_q <= '0;
            MonDReg    <= '0;
        end else begin
            ram_wr <= 1'b0;
            ram_rd <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        if (grant_owner == OWNER_JTAG) begin
                            ram_addr <= jtag_addr;
                            if (jtag_pend_wr) begin
                                ram_wr    <= 1'b1;
                                ram_wdata <= jtag_pend_data;
                                state     <= ST_J_WR;
                            end else begin
                                ram_rd <= 1'b1;
                                state  <= ST_J_RD;
                            end
                        end else begin
                            ram_addr <= av_address;
                            if (av_write) begin
                                ram_wr    <= 1'b1;
                                ram_wdata <= av_writedata;
                                state     <= ST_AV_WR;
                            end else begin
                                ram_rd <= 1'b1;
                                state  <= ST_AV_RD;
                            end
                        end
                    end
                end
                ST_AV_WR:      state <= ST_IDLE;
                ST_AV_RD:      state <= ST_AV_RD_DONE;
                ST_AV_RD_DONE: begin
                    av_rdata_q <= ram_rdata;
                    state      <= ST_IDLE;
                end
                ST_J_WR:       state <= ST_IDLE;
                ST_J_RD:       state <= ST_J_RD_DONE;
                ST_J_RD_DONE: begin
                    MonDReg <= ram_rdata;
                    state   <= ST_IDLE;
                end
                default:       state <= ST_IDLE;
            endcase
        end
    end

`ifdef DEBUG_MEM_ARB_OVF_EN
    logic strobe_drop;
    logic ovf_q;

    assign strobe_drop = strobe_any & jtag_busy;
    assign jtag_ovf    = ovf_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
        end else if (strobe_drop) begin
            ovf_q <= 1'b1;
        end else if (take_action_ocimem_a && jdo[36]) begin
            ovf_q <= 1'b0;
        end
    end
`else
    assign jtag_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_nios2_qsys_nios2_cpu_debug_mem_arbiter.sv
// Directed bench for the debug RAM arbiter with a synchronous RAM model.
module tb_nios2_qsys_nios2_cpu_debug_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [37:0] jdo = '0;
    logic        take_action_ocimem_a = 1'b0;
    logic        take_action_ocimem_b = 1'b0;
    logic        take_no_action_ocimem_a = 1'b0;
    logic [7:0]  av_address = '0;
    logic        av_read = 1'b0;
    logic        av_write = 1'b0;
    logic [31:0] av_writedata = '0;
    logic        av_waitrequest;
    logic [31:0] av_readdata;
    logic [7:0]  ram_addr;
    logic        ram_wr;
    logic        ram_rd;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [31:0] MonDReg;
    logic        jtag_busy;
    logic        jtag_ovf;

    logic [31:0] mem [0:255];
    int errors = 0;
    int checks = 0;

`ifdef DEBUG_MEM_ARB_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    nios2_qsys_nios2_cpu_debug_mem_arbiter #(.RAM_AW(8)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .av_address              (av_address),
        .av_read                 (av_read),
        .av_write                (av_write),
        .av_writedata            (av_writedata),
        .av_waitrequest          (av_waitrequest),
        .av_readdata             (av_readdata),
        .ram_addr                (ram_addr),
        .ram_wr                  (ram_wr),
        .ram_rd                  (ram_rd),
        .ram_wdata               (ram_wdata),
        .ram_rdata               (ram_rdata),
        .MonDReg                 (MonDReg),
        .jtag_busy               (jtag_busy),
        .jtag_ovf                (jtag_ovf)
    );

    always #5 clk = ~clk;

    // RAM: word i preloads to {4{i}} except a few marked locations.
    initial begin
        ram_rdata = '0;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] a;
            a = 8'(i);
            mem[i] = {a, a, a, a};
        end
        mem[8'h10] = 32'hDEADBEEF;
        mem[8'h02] = 32'hCCCCCCCC;
        mem[8'h03] = 32'hCCCCCCCC;
        forever begin
            @(posedge clk);
            if (ram_wr) mem[ram_addr] <= ram_wdata;
            if (ram_rd) ram_rdata <= mem[ram_addr];
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            checks++;
            assert (!(ram_wr && ram_rd)) else begin
                errors++;
                $error("FAIL ram_excl: observed wr=%0b rd=%0b expected not both", ram_wr, ram_rd);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    function automatic logic [37:0] jdo_a(logic [7:0] a, logic rd, logic clr);
        return {1'b0, clr, rd, 1'b0, a, 26'd0};
    endfunction

    function automatic logic [37:0] jdo_b(logic [31:0] d);
        return {3'b000, d, 3'b000};
    endfunction

    task automatic pulse_a(input logic [37:0] d);
        jdo = d;
        take_action_ocimem_a = 1'b1;
        cyc(1);
        take_action_ocimem_a = 1'b0;
    endtask

    task automatic pulse_b(input logic [31:0] d);
        jdo = jdo_b(d);
        take_action_ocimem_b = 1'b1;
        cyc(1);
        take_action_ocimem_b = 1'b0;
    endtask

    task automatic pulse_noact();
        take_no_action_ocimem_a = 1'b1;
        cyc(1);
        take_no_action_ocimem_a = 1'b0;
    endtask

    initial begin
        // reset values
        #1 reset_n = 1'b0;
        #1;
        chk("rst_mondreg", MonDReg, 32'h0);
        chk("rst_readdata", av_readdata, 32'h0);
        chk("rst_ram_wr", 32'(ram_wr), 32'h0);
        chk("rst_ram_rd", 32'(ram_rd), 32'h0);
        chk("rst_busy", 32'(jtag_busy), 32'h0);
        chk("rst_ovf", 32'(jtag_ovf), 32'h0);
        chk("rst_waitreq", 32'(av_waitrequest), 32'h0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;

        // JTAG read at 0x10
        pulse_a(jdo_a(8'h10, 1'b1, 1'b0));
        chk("jrd_busy_pend", 32'(jtag_busy), 32'h1);
        cyc(1);
        chk("jrd_ram_rd", 32'(ram_rd), 32'h1);
        chk("jrd_ram_addr", 32'(ram_addr), 32'h10);
        cyc(1);
        chk("jrd_mon_early", MonDReg, 32'h0);
        cyc(1);
        chk("jrd_mon", MonDReg, 32'hDEADBEEF);
        pulse_noact();
        cyc(3);
        chk("jrd_addr_inc", MonDReg, 32'h11111111);

        // JTAG writes wrapping from 0xFF
        pulse_a(jdo_a(8'hFF, 1'b0, 1'b0));
        cyc(3);
        pulse_b(32'd1);
        cyc(3);
        pulse_b(32'd2);
        cyc(3);
        pulse_b(32'd3);
        cyc(3);
        chk("jwr_ff", mem[8'hFF], 32'd1);
        chk("jwr_00", mem[8'h00], 32'd2);
        chk("jwr_01", mem[8'h01], 32'd3);
        chk("jwr_no_ovf", 32'(jtag_ovf), 32'h0);

        // back-to-back write strobes: second dropped
        jdo = jdo_b(32'hA5);
        take_action_ocimem_b = 1'b1;
        cyc(1);
        jdo = jdo_b(32'h5A);
        cyc(1);
        take_action_ocimem_b = 1'b0;
        cyc(3);
        chk("ovf_flag", 32'(jtag_ovf), 32'(OVF_EXP));
        chk("ovf_mem2", mem[8'h02], 32'hA5);
        chk("ovf_mem3", mem[8'h03], 32'hCCCCCCCC);
        pulse_noact();
        cyc(3);
        chk("ovf_next_addr", MonDReg, 32'hCCCCCCCC);

        // strobe accepted in the completing cycle; also clears overflow
        pulse_a(jdo_a(8'h20, 1'b1, 1'b1));
        cyc(2);
        chk("done_busy", 32'(jtag_busy), 32'h0);
        pulse_noact();
        chk("done_mon", MonDReg, 32'h20202020);
        chk("ovf_cleared", 32'(jtag_ovf), 32'h0);
        cyc(3);
        chk("done_next", MonDReg, 32'h21212121);

        // Avalon write, read, write+read
        av_address = 8'h40;
        av_writedata = 32'h12345678;
        av_write = 1'b1;
        #1 chk("avw_wait", 32'(av_waitrequest), 32'h1);
        cyc(1);
        chk("avw_done_wait", 32'(av_waitrequest), 32'h0);
        chk("avw_ram_wr", 32'(ram_wr), 32'h1);
        cyc(1);
        av_write = 1'b0;
        chk("avw_mem", mem[8'h40], 32'h12345678);
        av_read = 1'b1;
        #1 chk("avr_wait0", 32'(av_waitrequest), 32'h1);
        cyc(1);
        chk("avr_wait1", 32'(av_waitrequest), 32'h1);
        cyc(1);
        chk("avr_done_wait", 32'(av_waitrequest), 32'h0);
        chk("avr_data", av_readdata, 32'h12345678);
        cyc(1);
        av_read = 1'b0;
        #1 chk("avr_data_hold", av_readdata, 32'h12345678);
        av_address = 8'h41;
        av_writedata = 32'h0BADF00D;
        av_read = 1'b1;
        av_write = 1'b1;
        cyc(1);
        chk("avrw_wait", 32'(av_waitrequest), 32'h0);
        chk("avrw_no_rd", 32'(ram_rd), 32'h0);
        cyc(1);
        av_read = 1'b0;
        av_write = 1'b0;
        chk("avrw_mem", mem[8'h41], 32'h0BADF00D);
        chk("avrw_rdata", av_readdata, 32'h12345678);

        // tie after reset: JTAG first
        reset_n = 1'b0;
        cyc(1);
        reset_n = 1'b1;
        pulse_a(jdo_a(8'h30, 1'b1, 1'b0));
        av_address = 8'h50;
        av_read = 1'b1;
        #1 chk("tie_wait0", 32'(av_waitrequest), 32'h1);
        cyc(1);
        chk("tie_j_addr", 32'(ram_addr), 32'h30);
        chk("tie_j_rd", 32'(ram_rd), 32'h1);
        chk("tie_wait1", 32'(av_waitrequest), 32'h1);
        cyc(1);
        chk("tie_wait2", 32'(av_waitrequest), 32'h1);
        cyc(1);
        chk("tie_mon", MonDReg, 32'h30303030);
        chk("tie_wait3", 32'(av_waitrequest), 32'h1);
        cyc(1);
        chk("tie_av_addr", 32'(ram_addr), 32'h50);
        chk("tie_wait4", 32'(av_waitrequest), 32'h1);
        cyc(1);
        chk("tie_av_done", 32'(av_waitrequest), 32'h0);
        chk("tie_av_data", av_readdata, 32'h50505050);
        cyc(1);
        av_read = 1'b0;

        // JTAG served last, so the next tie goes to the CPU
        pulse_noact();
        cyc(3);
        chk("rr_j_alone", MonDReg, 32'h31313131);
        pulse_noact();
        av_read = 1'b1;
        cyc(1);
        chk("rr_cpu_addr", 32'(ram_addr), 32'h50);
        chk("rr_cpu_rd", 32'(ram_rd), 32'h1);
        chk("rr_j_waiting", 32'(jtag_busy), 32'h1);
        cyc(1);
        chk("rr_cpu_done", 32'(av_waitrequest), 32'h0);
        chk("rr_cpu_data", av_readdata, 32'h50505050);
        cyc(1);
        av_read = 1'b0;
        cyc(3);
        chk("rr_j_after", MonDReg, 32'h32323232);

        // reset during an Avalon read
        av_address = 8'h40;
        av_read = 1'b1;
        cyc(1);
        chk("rstrd_rd", 32'(ram_rd), 32'h1);
        #1 reset_n = 1'b0;
        #1;
        chk("rstrd_ram_rd", 32'(ram_rd), 32'h0);
        chk("rstrd_rdata", av_readdata, 32'h0);
        chk("rstrd_wait", 32'(av_waitrequest), 32'h1);
        chk("rstrd_mon", MonDReg, 32'h0);
        chk("rstrd_busy", 32'(jtag_busy), 32'h0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        cyc(1);
        chk("rstrd_restart", 32'(ram_rd), 32'h1);
        chk("rstrd_wait1", 32'(av_waitrequest), 32'h1);
        cyc(1);
        chk("rstrd_done", 32'(av_waitrequest), 32'h0);
        chk("rstrd_data", av_readdata, 32'h12345678);
        cyc(1);
        av_read = 1'b0;
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nios2_qsys_nios2_cpu_debug_mem_arbiter.md
NIOS2_QSYS_NIOS2_CPU_DEBUG_MEM_ARBITER -- requirements
Module: nios2_qsys_nios2_cpu_debug_mem_arbiter

Interface
REQ-001 Parameter RAM_AW, default 8: OCI debug RAM word-address width.
REQ-002 clk  in  1: single system clock; all state updates on rising edge.
REQ-003 reset_n  in  1: asynchronous, active-low reset.
REQ-004 jdo  in  38: JTAG data word from the debug slave sysclk domain.
REQ-005 take_action_ocimem_a / take_action_ocimem_b / take_no_action_ocimem_a  in  1 each: single-cycle JTAG command strobes.
REQ-006 av_address  in  RAM_AW: CPU word address. av_read / av_write  in  1 each. av_writedata  in  32.
REQ-007 av_waitrequest  out  1. av_readdata  out  32.
REQ-008 ram_addr  out  RAM_AW. ram_wr, ram_rd  out  1 each. ram_wdata  out  32. ram_rdata  in  32 (valid one cycle after ram_rd).
REQ-009 MonDReg  out  32: last JTAG read data. jtag_busy  out  1. jtag_ovf  out  1: sticky overflow.

Function
REQ-010 take_action_ocimem_a: load jtag_addr <= jdo[RAM_AW+25:26]; when jdo[35]=1, also post a JTAG read at the new address.
REQ-011 take_action_ocimem_b: post a JTAG write of jdo[34:3] at jtag_addr.
REQ-012 take_no_action_ocimem_a: post a JTAG read at jtag_addr.
REQ-013 JTAG requests are held in a 1-deep pending register; jtag_busy = pending OR JTAG access in flight.
REQ-014 Strobe arriving while jtag_busy=1: dropped, jtag_ovf set (see REQ-026).
REQ-015 FSM states: IDLE, AV_WR, AV_RD, AV_RD_DONE, J_WR, J_RD, J_RD_DONE.
REQ-016 From IDLE, when exactly one requester is pending, grant it; when both are pending, grant the one not granted last (round-robin). last_grant resets to CPU, so JTAG wins the first tie.
REQ-017 AV_WR: ram_wr=1, ram_addr=av_address, ram_wdata=av_writedata, av_waitrequest=0 for one cycle -> IDLE.
REQ-018 AV_RD: ram_rd=1 -> AV_RD_DONE: av_readdata<=ram_rdata, av_waitrequest=0 -> IDLE. Read latency is 2 cycles from grant.
REQ-019 J_WR: ram_wr=1 at jtag_addr; jtag_addr increments by 1 after the write -> IDLE.
REQ-020 J_RD: ram_rd=1 -> J_RD_DONE: MonDReg<=ram_rdata; jtag_addr increments by 1 -> IDLE.
REQ-021 jtag_addr wraps from 2^RAM_AW-1 to 0 with no flag.
REQ-022 av_waitrequest=1 whenever av_read or av_write is asserted and the access is not in its completing cycle; av_read and av_write both high: write is taken, read is ignored.
REQ-023 A strobe in the same cycle a JTAG access completes is accepted (busy clears combinationally from J_WR / J_RD_DONE).
REQ-024 ram_wr and ram_rd are never asserted together; at most one RAM access per cycle.

Reset
REQ-025 Asynchronous reset returns state to IDLE: outputs jtag_addr=0, MonDReg=0, av_readdata=0, ram_wr=0, ram_rd=0, jtag_busy=0, jtag_ovf=0, last_grant=CPU, and the pending request is cleared; a RAM access in flight is abandoned.

Configuration
REQ-026 Macro DEBUG_MEM_ARB_OVF_EN defined: jtag_ovf is sticky and is cleared only by take_action_ocimem_a with jdo[36]=1. Macro not defined: jtag_ovf is tied 0, and overflowing strobes are dropped silently.

Structure
REQ-027 The FSM state enum and the grant-owner encoding belong in the shared nios2_qsys_nios2_cpu_debug_pkg.
REQ-028 One sub-module, nios2_qsys_nios2_cpu_debug_mem_rr_arb (2-requester round-robin with last_grant register); everything else is flat.

Verification
REQ-029 ocimem_a with jdo[33:26]=8'h10 and jdo[35]=1, RAM[0x10]=32'hDEADBEEF -> MonDReg=32'hDEADBEEF 3 cycles after the strobe; jtag_addr=8'h11.
REQ-030 Three ocimem_b strobes, spaced 4 cycles apart, writing 1,2,3 from jtag_addr=8'hFF -> RAM[FF]=1, RAM[00]=2, RAM[01]=3 (wrap).
REQ-031 Avalon read and JTAG read both pending in the same cycle after reset -> JTAG is granted first; the Avalon read completes 3 cycles later, av_waitrequest=1 until then.
REQ-032 Two ocimem_b strobes on consecutive cycles -> the second is dropped and jtag_ovf=1 (macro on) or 0 (macro off); the RAM is written once.
REQ-033 reset_n asserted during AV_RD -> state IDLE, av_readdata=0 and ram_rd=0 immediately; av_read still high after release -> read restarts and completes in 2 cycles.
